// File: rtl/lab3_mem_line_mem_responder_if.sv
// rtl/lab3_mem_line_mem_responder_if.sv - memory request/response stream bundle between cache and line memory
// master = cache side (drives requests), slave = memory responder.
interface lab3_mem_line_mem_responder_if;
  logic         memreq_val;
  logic         memreq_rdy;
  logic [3:0]   memreq_type;
  logic [7:0]   memreq_opaque;
  logic [31:0]  memreq_addr;
  logic [3:0]   memreq_len;
  logic [127:0] memreq_data;

  logic         memresp_val;
  logic         memresp_rdy;
  logic [3:0]   memresp_type;
  logic [7:0]   memresp_opaque;
  logic [1:0]   memresp_test;
  logic [3:0]   memresp_len;
  logic [127:0] memresp_data;

  modport master (
    output memreq_val, memreq_type, memreq_opaque, memreq_addr, memreq_len, memreq_data,
    input  memreq_rdy,
    input  memresp_val, memresp_type, memresp_opaque, memresp_test, memresp_len, memresp_data,
    output memresp_rdy
  );

  modport slave (
    input  memreq_val, memreq_type, memreq_opaque, memreq_addr, memreq_len, memreq_data,
    output memreq_rdy,
    output memresp_val, memresp_type, memresp_opaque, memresp_test, memresp_len, memresp_data,
    input  memresp_rdy
  );
endinterface

// File: rtl/lab3_mem_line_mem_responder.sv
// rtl/lab3_mem_line_mem_responder.sv - line-organized memory responder with programmable response latency
// Optional LAB3_MEM_RANDOM_DELAY_EN adds 0..3 LFSR-driven extra delay cycles per request.
module lab3_mem_line_mem_responder #(
  parameter int p_num_lines = 64,
  parameter int p_latency   = 2
) (
  input  logic clk,
  input  logic reset,
  lab3_mem_line_mem_responder_if.slave bus
);

  localparam int p_idx_w = (p_num_lines > 1) ? $clog2(p_num_lines) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, RESP} state_t;

  state_t       state, next_state;
  logic [4:0]   cnt;
  logic [4:0]   total;
  logic         accept;
  logic [127:0] mem [p_num_lines];

  logic [p_idx_w-1:0] idx;
  logic [6:0]         sh;
  logic [127:0]       line, len_mask, wr_mask, rd_data, wr_line;
  logic               is_read, is_write;
  logic               unused_addr;

  assign accept   = bus.memreq_val && bus.memreq_rdy;
  assign is_read  = (bus.memreq_type == 4'd0);
  assign is_write = (bus.memreq_type == 4'd1) || (bus.memreq_type == 4'd2);

`ifdef LAB3_MEM_RANDOM_DELAY_EN
  logic [7:0] lfsr;

  assign total = 5'(p_latency) + {3'b000, lfsr[1:0]};

  // Fibonacci taps 8,6,5,4; steps once per accepted request
  always_ff @(posedge clk) begin
    if (reset)
      lfsr <= 8'hA5;
    else if (accept)
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
`else
  assign total = 5'(p_latency);
`endif

  // Upper address bits alias onto the line array
  assign unused_addr = ^bus.memreq_addr;
  assign idx         = bus.memreq_addr[4 +: p_idx_w];
  assign line        = mem[idx];

  // len==0 is a whole-line access with the offset ignored
  assign sh       = (bus.memreq_len == 4'd0) ? 7'd0 : {bus.memreq_addr[3:0], 3'b000};
  assign len_mask = (bus.memreq_len == 4'd0) ? {128{1'b1}}
                                             : ((128'd1 << {bus.memreq_len, 3'b000}) - 128'd1);
  assign rd_data  = (line >> sh) & len_mask;
  assign wr_mask  = len_mask << sh;
  assign wr_line  = (line & ~wr_mask) | ((bus.memreq_data << sh) & wr_mask);

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state      = state;
    bus.memreq_rdy  = 1'b0;
    bus.memresp_val = 1'b0;
    case (state)
      IDLE: begin
        bus.memreq_rdy = 1'b1;
        if (bus.memreq_val)
          next_state = (total == 5'd0) ? RESP : DELAY;
      end
      DELAY: begin
        if (cnt == 5'd1)
          next_state = RESP;
      end
      RESP: begin
        bus.memresp_val = 1'b1;
        if (bus.memresp_rdy)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.memresp_test = 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt                <= 5'd0;
      bus.memresp_type   <= 4'd0;
      bus.memresp_opaque <= 8'd0;
      bus.memresp_len    <= 4'd0;
      bus.memresp_data   <= 128'd0;
      for (int i = 0; i < p_num_lines; i++)
        mem[i] <= 128'd0;
    end else if (accept) begin
      cnt                <= total;
      bus.memresp_type   <= bus.memreq_type;
      bus.memresp_opaque <= bus.memreq_opaque;
      bus.memresp_len    <= bus.memreq_len;
      bus.memresp_data   <= is_read ? rd_data : 128'd0;
      if (is_write)
        mem[idx] <= wr_line;
    end else if (state == DELAY) begin
      cnt <= cnt - 5'd1;
    end
  end

endmodule

// File: tb/tb_lab3_mem_line_mem_responder.sv
// tb/tb_lab3_mem_line_mem_responder.sv - self-checking bench for lab3_mem_line_mem_responder
// Byte-array reference model; timing derived from the configured latency.
module tb_lab3_mem_line_mem_responder;

  localparam int P_LINES = 64;
  localparam int P_LAT   = 2;

  typedef struct {
    int           lat;
    int           exp_lat;
    bit           rdy_low_ok;
    bit           stable_ok;
    bit           rdy_after;
    logic [3:0]   typ;
    logic [7:0]   op;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] ref_mem [P_LINES][16];
  logic [7:0] m_lfsr;

  lab3_mem_line_mem_responder_if bus ();

  lab3_mem_line_mem_responder #(.p_num_lines(P_LINES), .p_latency(P_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int l = 0; l < P_LINES; l++)
      for (int b = 0; b < 16; b++)
        ref_mem[l][b] = 8'h00;
    m_lfsr = 8'hA5;
  endtask

  task automatic model_apply(input logic [3:0] typ, input logic [31:0] addr, input logic [3:0] len,
                             input logic [127:0] data, output logic [127:0] exp);
    int idx, off, n;
    idx = int'((addr >> 4) % P_LINES);
    off = int'(addr[3:0]);
    n   = (len == 0) ? 16 : int'(len);
    exp = '0;
    for (int i = 0; i < n; i++) begin
      int pos;
      pos = (len == 0) ? i : off + i;
      if (pos < 16) begin
        if (typ == 4'd0)
          exp[i*8 +: 8] = ref_mem[idx][pos];
        else if (typ == 4'd1 || typ == 4'd2)
          ref_mem[idx][pos] = data[i*8 +: 8];
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.memreq_val = 1'b0;
    bus.memresp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic do_txn(input logic [3:0] typ, input logic [7:0] op, input logic [31:0] addr,
                        input logic [3:0] len, input logic [127:0] data, input int hold,
                        output resp_t r);
    int w;
    r.rdy_low_ok = 1'b1;
    r.stable_ok  = 1'b1;
    r.rdy_after  = 1'b0;
    @(negedge clk);
    bus.memreq_val    = 1'b1;
    bus.memreq_type   = typ;
    bus.memreq_opaque = op;
    bus.memreq_addr   = addr;
    bus.memreq_len    = len;
    bus.memreq_data   = data;
    bus.memresp_rdy   = 1'b0;
    w = 0;
    while (!bus.memreq_rdy && w < 50) begin
      @(negedge clk);
      w++;
    end
    r.exp_lat = 1 + P_LAT;
`ifdef LAB3_MEM_RANDOM_DELAY_EN
    r.exp_lat = r.exp_lat + int'(m_lfsr[1:0]);
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
    if (w >= 50) begin
      bus.memreq_val = 1'b0;
      r.lat = -1;
      return;
    end
    @(posedge clk);
    #1 bus.memreq_val = 1'b0;
    r.lat = 0;
    do begin
      @(negedge clk);
      r.lat++;
      if (bus.memreq_rdy) r.rdy_low_ok = 1'b0;
    end while (!bus.memresp_val && r.lat < 100);
    r.typ  = bus.memresp_type;
    r.op   = bus.memresp_opaque;
    r.test = bus.memresp_test;
    r.len  = bus.memresp_len;
    r.data = bus.memresp_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!bus.memresp_val || bus.memreq_rdy || bus.memresp_type !== r.typ ||
          bus.memresp_opaque !== r.op || bus.memresp_len !== r.len || bus.memresp_data !== r.data)
        r.stable_ok = 1'b0;
    end
    bus.memresp_rdy = 1'b1;
    @(posedge clk);
    #1 bus.memresp_rdy = 1'b0;
    @(negedge clk);
    r.rdy_after = bus.memreq_rdy && !bus.memresp_val;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.memreq_rdy !== 1'b1 || bus.memresp_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: rdy=%b val=%b expected rdy=1 val=0", bus.memreq_rdy, bus.memresp_val);
    end
    checks++;
    if ({bus.memresp_type, bus.memresp_opaque, bus.memresp_test, bus.memresp_len, bus.memresp_data} !== '0) begin
      errors++;
      $display("FAIL reset_fields: type=%h op=%h test=%h len=%h data=%h expected all 0",
               bus.memresp_type, bus.memresp_opaque, bus.memresp_test, bus.memresp_len, bus.memresp_data);
    end
  endtask

  task automatic test_write_init_read();
    resp_t r;
    logic [127:0] exp;
    logic [127:0] line = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    model_apply(4'd2, 32'h40, 4'd0, line, exp);
    do_txn(4'd2, 8'h11, 32'h40, 4'd0, line, 0, r);
    checks++;
    if (r.data !== 128'd0 || r.typ !== 4'd2 || r.op !== 8'h11) begin
      errors++;
      $display("FAIL winit_resp: type=%h op=%h data=%h expected type=2 op=11 data=0", r.typ, r.op, r.data);
    end
    do_txn(4'd0, 8'h5A, 32'h40, 4'd0, 128'd0, 0, r);
    checks++;
    if (r.data !== line) begin
      errors++;
      $display("FAIL winit_readback: data=%h expected %h", r.data, line);
    end
    checks++;
    if (r.op !== 8'h5A || r.test !== 2'd0 || r.typ !== 4'd0 || r.len !== 4'd0) begin
      errors++;
      $display("FAIL read_echo: op=%h test=%h type=%h len=%h expected 5a 0 0 0", r.op, r.test, r.typ, r.len);
    end
  endtask

  task automatic test_latency();
    resp_t r;
    do_txn(4'd0, 8'h21, 32'h80, 4'd0, 128'd0, 0, r);
    checks++;
    if (r.lat !== r.exp_lat) begin
      errors++;
      $display("FAIL latency: cycles=%0d expected %0d", r.lat, r.exp_lat);
    end
    checks++;
    if (!r.rdy_low_ok || !r.rdy_after) begin
      errors++;
      $display("FAIL req_rdy_window: low_while_busy=%b high_after=%b expected 1 1", r.rdy_low_ok, r.rdy_after);
    end
  endtask

  task automatic test_partial();
    resp_t r;
    logic [127:0] exp;
    do_reset();
    model_apply(4'd1, 32'h44, 4'd4, 128'hDEADBEEF, exp);
    do_txn(4'd1, 8'h31, 32'h44, 4'd4, 128'hDEADBEEF, 0, r);
    do_txn(4'd0, 8'h32, 32'h40, 4'd0, 128'd0, 0, r);
    checks++;
    if (r.data !== 128'h00000000_00000000_DEADBEEF_00000000) begin
      errors++;
      $display("FAIL partial_write_line: data=%h expected 00000000_00000000_deadbeef_00000000", r.data);
    end
    do_txn(4'd0, 8'h33, 32'h46, 4'd4, 128'd0, 0, r);
    checks++;
    if (r.data !== 128'h0000DEAD || r.len !== 4'd4) begin
      errors++;
      $display("FAIL partial_read: data=%h len=%h expected 0000dead len=4", r.data, r.len);
    end
  endtask

  task automatic test_backpressure();
    resp_t r;
    logic [127:0] exp;
    model_apply(4'd0, 32'h40, 4'd0, 128'd0, exp);
    do_txn(4'd0, 8'h44, 32'h40, 4'd0, 128'd0, 10, r);
    checks++;
    if (!r.stable_ok) begin
      errors++;
      $display("FAIL hold_stable: stable=%b expected 1", r.stable_ok);
    end
    checks++;
    if (!r.rdy_after || r.data !== exp) begin
      errors++;
      $display("FAIL hold_release: idle=%b data=%h expected idle=1 data=%h", r.rdy_after, r.data, exp);
    end
  endtask

  task automatic test_alias();
    resp_t r;
    logic [127:0] d, e, exp;
    d = {$urandom, $urandom, $urandom, $urandom};
    e = {$urandom, $urandom, $urandom, $urandom};
    model_apply(4'd1, 32'h400, 4'd0, d, exp);
    do_txn(4'd1, 8'h51, 32'h400, 4'd0, d, 0, r);
    model_apply(4'd0, 32'h000, 4'd0, 128'd0, exp);
    do_txn(4'd0, 8'h52, 32'h000, 4'd0, 128'd0, 0, r);
    checks++;
    if (r.data !== d) begin
      errors++;
      $display("FAIL alias_read: data=%h expected %h", r.data, d);
    end
    model_apply(4'd1, 32'h0C, 4'd8, e, exp);
    do_txn(4'd1, 8'h53, 32'h0C, 4'd8, e, 0, r);
    model_apply(4'd0, 32'h00, 4'd0, 128'd0, exp);
    do_txn(4'd0, 8'h54, 32'h00, 4'd0, 128'd0, 0, r);
    checks++;
    if (r.data !== {e[31:0], d[95:0]} || r.data !== exp) begin
      errors++;
      $display("FAIL line_clip: data=%h expected %h", r.data, {e[31:0], d[95:0]});
    end
  endtask

  task automatic test_reset_mid();
    resp_t r;
    int seen;
    logic [127:0] exp;
    @(negedge clk);
    bus.memreq_val    = 1'b1;
    bus.memreq_type   = 4'd2;
    bus.memreq_opaque = 8'h61;
    bus.memreq_addr   = 32'hC0;
    bus.memreq_len    = 4'd0;
    bus.memreq_data   = {4{32'hCAFEF00D}};
    @(posedge clk);
    #1 bus.memreq_val = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.memresp_val) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_abandon: resp_val cycles=%0d expected 0", seen);
    end
    model_apply(4'd0, 32'hC0, 4'd0, 128'd0, exp);
    do_txn(4'd0, 8'h62, 32'hC0, 4'd0, 128'd0, 0, r);
    checks++;
    if (r.data !== 128'd0 || r.data !== exp) begin
      errors++;
      $display("FAIL reset_cleared: data=%h expected 0", r.data);
    end
  endtask

  task automatic test_random();
    resp_t r;
    logic [127:0] exp, d;
    logic [3:0] typ, len;
    logic [31:0] addr;
    logic [3:0] types [6] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd9};
    int bad;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      typ  = types[$urandom_range(0, 5)];
      addr = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 32'h7FF);
      len  = 4'($urandom_range(0, 15));
      d    = {$urandom, $urandom, $urandom, $urandom};
      model_apply(typ, addr, len, d, exp);
      do_txn(typ, 8'(i), addr, len, d, $urandom_range(0, 3), r);
      checks++;
      if (r.data !== exp || r.typ !== typ || r.op !== 8'(i) || r.len !== len || r.test !== 2'd0 ||
          r.lat !== r.exp_lat || !r.rdy_low_ok || !r.stable_ok || !r.rdy_after) begin
        errors++;
        bad++;
        if (bad < 6)
          $display("FAIL random_%0d: type=%h len=%h addr=%h data=%h lat=%0d expected data=%h lat=%0d",
                   i, typ, len, addr, r.data, r.lat, exp, r.exp_lat);
      end
    end
  endtask

  initial begin
    bus.memreq_val    = 1'b0;
    bus.memreq_type   = 4'd0;
    bus.memreq_opaque = 8'd0;
    bus.memreq_addr   = 32'd0;
    bus.memreq_len    = 4'd0;
    bus.memreq_data   = 128'd0;
    bus.memresp_rdy   = 1'b0;
    model_clear();
    test_reset();
    test_write_init_read();
    test_latency();
    test_partial();
    test_backpressure();
    test_alias();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
